pc_fetch_sequencer: RTL and testbench

- Multicycle fetch/PC-register block for the 16-bit core.
- Owns the architectural PC and presents it to the next-PC ALU as `pc_out`.
- Accepts the next PC and link value computed by that ALU.
- Runs the instruction-memory request/ack handshake and hands fetched instructions to decode with a valid/ready handshake.

---
 rtl/pc_fetch_sequencer_if.sv | 37 +++
 rtl/pc_fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bus bundle: PC ALU hand-off, instruction-memory
// request/ack, decode valid/ready, link write-back and status flags.
// master = the sequencer itself, slave = the surrounding core / memory.
interface pc_fetch_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc_next;
    logic             pc_load;
    logic [WIDTH-1:0] rlink_in;
    logic             rlink_valid;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_req;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] instr_out;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] link_out;
    logic             link_we;
    logic             seq_err;
    logic             fetch_fault;

    modport master (
        input  pc_next, pc_load, rlink_in, rlink_valid,
        input  mem_ack, mem_rdata, instr_ready,
        output pc_out, mem_addr, mem_req, instr_out, instr_valid,
        output link_out, link_we, seq_err, fetch_fault
    );

    modport slave (
        output pc_next, pc_load, rlink_in, rlink_valid,
        output mem_ack, mem_rdata, instr_ready,
        input  pc_out, mem_addr, mem_req, instr_out, instr_valid,
        input  link_out, link_we, seq_err, fetch_fault
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch / PC-register sequencer for the 16-bit core.
// Owns the PC, runs the imem req/ack handshake, hands the fetched word to
// decode (valid/ready) and waits for the next PC from the PC ALU.
// Optional feature macro: FETCH_TIMEOUT_EN (bounded wait for mem_ack,
// sticky fetch_fault on expiry; without it fetch_fault is constant 0).
module pc_fetch_sequencer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 8
) (
    input logic                 clk,
    input logic                 reset,
    pc_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_WAIT_PC} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             req_q;
    logic [WIDTH-1:0] instr_q;
    logic             ivld_q;
    logic [WIDTH-1:0] link_q;
    logic             lwe_q;
    logic             err_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
`endif

    // A load is accepted only once decode has (or is now) taking the word.
    logic load_go_d;
    always_comb begin
        load_go_d = bus.pc_load &&
                    ((state_q == S_WAIT_PC) ||
                     ((state_q == S_HOLD) && bus.instr_ready));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= '0;
            ivld_q  <= 1'b0;
            link_q  <= '0;
            lwe_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            lwe_q <= 1'b0;
            if (load_go_d) begin
                // Load also restarts the fetch at the new PC right away.
                pc_q    <= bus.pc_next;
                req_q   <= 1'b1;
                ivld_q  <= 1'b0;
                state_q <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                cnt_q   <= '0;
`endif
                if (bus.rlink_valid) begin
                    link_q <= bus.rlink_in;
                    lwe_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (bus.pc_load) err_q <= 1'b1;
                        if (!req_q) begin
                            // First cycle after reset: raise the request.
                            req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                        end else if (bus.mem_ack) begin
                            // Ack beats a simultaneous timeout.
                            instr_q <= bus.mem_rdata;
                            ivld_q  <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= S_HOLD;
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (cnt_q == TO_LAST) begin
                            req_q   <= 1'b0;
                            fault_q <= 1'b1;
                            state_q <= S_WAIT_PC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                    S_HOLD: begin
                        if (bus.instr_ready) begin
                            ivld_q  <= 1'b0;
                            state_q <= S_WAIT_PC;
                        end else if (bus.pc_load) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_WAIT_PC: begin
                        // Only pc_load (handled above) leaves this state.
                    end
                    default: state_q <= S_REQ;
                endcase
            end
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.mem_addr    = pc_q;
    assign bus.mem_req     = req_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = ivld_q;
    assign bus.link_out    = link_q;
    assign bus.link_we     = lwe_q;
    assign bus.seq_err     = err_q;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fetch_fault = fault_q;
`else
    // No timeout hardware: flag is constant 0 for every legal TIMEOUT.
    assign bus.fetch_fault = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed test-plan steps followed by
// randomized traffic, all checked against a transaction-level model.
module tb_pc_fetch_sequencer;
    localparam int          W        = 16;
    localparam logic [15:0] RST_PC   = 16'h0000;
    localparam int          TO       = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.WIDTH(W)) ifc ();

    pc_fetch_sequencer #(.WIDTH(W), .RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: where the block is in its fetch/decode/wait round,
    // how long the current request has been outstanding, and the visible
    // architectural values.
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_IDLE = 2;
    int          m_phase;
    int          m_waited;
    logic        m_req;
    logic [15:0] m_pc, m_instr, m_link;
    logic        m_valid, m_lwe, m_err, m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_load(input logic [15:0] nxt, input logic lv, input logic [15:0] li);
        m_pc     = nxt;
        m_phase  = PH_FETCH;
        m_req    = 1'b1;
        m_waited = 0;
        m_valid  = 1'b0;
        if (lv) begin
            m_link = li;
            m_lwe  = 1'b1;
        end
    endtask

    // One clock: sample the driven inputs, advance, update model, compare.
    task automatic cycle();
        logic        r, ld, lv, ack, rdy;
        logic [15:0] nxt, li, rd;
        r = reset; ld = ifc.pc_load; lv = ifc.rlink_valid; ack = ifc.mem_ack;
        rdy = ifc.instr_ready; nxt = ifc.pc_next; li = ifc.rlink_in; rd = ifc.mem_rdata;
        @(posedge clk);
        #1;
        if (r) begin
            m_phase = PH_FETCH; m_waited = 0; m_req = 1'b0; m_pc = RST_PC;
            m_instr = '0; m_valid = 1'b0; m_link = '0; m_lwe = 1'b0;
            m_err = 1'b0; m_fault = 1'b0;
        end else begin
            m_lwe = 1'b0;
            if (m_phase == PH_FETCH) begin
                if (ld) m_err = 1'b1;
                if (!m_req) begin
                    m_req = 1'b1; m_waited = 0;
                end else if (ack) begin
                    m_instr = rd; m_valid = 1'b1; m_req = 1'b0; m_phase = PH_DECODE;
                end else begin
                    m_waited++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_waited >= TO) begin
                        m_req = 1'b0; m_fault = 1'b1; m_phase = PH_IDLE;
                    end
`endif
                end
            end else if (m_phase == PH_DECODE) begin
                if (rdy) begin
                    if (ld) accept_load(nxt, lv, li);
                    else begin m_valid = 1'b0; m_phase = PH_IDLE; end
                end else if (ld) m_err = 1'b1;
            end else begin
                if (ld) accept_load(nxt, lv, li);
            end
        end
        chk("pc_out",      ifc.pc_out,      m_pc);
        chk("mem_addr",    ifc.mem_addr,    m_pc);
        chk("mem_req",     ifc.mem_req,     m_req);
        chk("instr_out",   ifc.instr_out,   m_instr);
        chk("instr_valid", ifc.instr_valid, m_valid);
        chk("link_out",    ifc.link_out,    m_link);
        chk("link_we",     ifc.link_we,     m_lwe);
        chk("seq_err",     ifc.seq_err,     m_err);
        chk("fetch_fault", ifc.fetch_fault, m_fault);
    endtask

    task automatic drive(input logic ld, input logic [15:0] nxt, input logic lv,
                         input logic [15:0] li, input logic ack, input logic [15:0] rd,
                         input logic rdy);
        ifc.pc_load = ld; ifc.pc_next = nxt; ifc.rlink_valid = lv; ifc.rlink_in = li;
        ifc.mem_ack = ack; ifc.mem_rdata = rd; ifc.instr_ready = rdy;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 16'h0, 0, 16'h0, 1, 16'h1234, 0);
        cycle(); cycle();
        chk("rst_req", ifc.mem_req, 0);
        chk("rst_pc",  ifc.pc_out, RST_PC);
        chk("rst_iv",  ifc.instr_valid, 0);

        // First fetch after reset with ack held high.
        reset = 1'b0;
        cycle();
        chk("tp1_req",  ifc.mem_req, 1);
        chk("tp1_addr", ifc.mem_addr, 16'h0000);
        cycle();
        chk("tp1_iv",   ifc.instr_valid, 1);
        chk("tp1_ins",  ifc.instr_out, 16'h1234);

        // Accept, then plain load of 0x0042.
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1); cycle();
        drive(1, 16'h0042, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp2_pc",   ifc.pc_out, 16'h0042);
        chk("tp2_addr", ifc.mem_addr, 16'h0042);
        chk("tp2_lwe",  ifc.link_we, 0);

        // JAL-style load with link capture.
        drive(0, 16'h0, 0, 16'h0, 1, 16'hABCD, 0); cycle();
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1); cycle();
        drive(1, 16'h0100, 1, 16'h0043, 0, 16'h0, 0); cycle();
        chk("tp3_link", ifc.link_out, 16'h0043);
        chk("tp3_lwe",  ifc.link_we, 1);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp3_lwe1", ifc.link_we, 0);
        chk("tp3_addr", ifc.mem_addr, 16'h0100);

        // Ready and load together in decode hand-off, to 0xFFFF, then 0x0000.
        drive(0, 16'h0, 0, 16'h0, 1, 16'h5555, 0); cycle();
        drive(1, 16'hFFFF, 0, 16'h0, 0, 16'h0, 1); cycle();
        chk("tp4_req",  ifc.mem_req, 1);
        chk("tp4_addr", ifc.mem_addr, 16'hFFFF);
        drive(0, 16'h0, 0, 16'h0, 1, 16'h7777, 0); cycle();
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1); cycle();
        drive(1, 16'h0000, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp4_wrap", ifc.pc_out, 16'h0000);

        // Load while a request is outstanding: ignored, sticky error.
        drive(1, 16'h1234, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp5_pc",  ifc.pc_out, 16'h0000);
        chk("tp5_err", ifc.seq_err, 1);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0); cycle(); cycle();
        chk("tp5_stk", ifc.seq_err, 1);
        reset = 1'b1; ifc.mem_ack = 1'b1; cycle();
        chk("tp5_rreq", ifc.mem_req, 0);
        chk("tp5_rerr", ifc.seq_err, 0);
        reset = 1'b0; ifc.mem_ack = 1'b0;

        // Memory never answers.
        for (int i = 0; i < TO + 4; i++) cycle();
`ifdef FETCH_TIMEOUT_EN
        chk("tp6_req",   ifc.mem_req, 0);
        chk("tp6_fault", ifc.fetch_fault, 1);
        drive(1, 16'h0010, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp6_addr",  ifc.mem_addr, 16'h0010);
        chk("tp6_freq",  ifc.mem_req, 1);
`else
        chk("tp6_req",   ifc.mem_req, 1);
        chk("tp6_fault", ifc.fetch_fault, 0);
        drive(1, 16'h0010, 0, 16'h0, 0, 16'h0, 0); cycle();
        chk("tp6_pc",    ifc.pc_out, RST_PC);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            ifc.mem_ack     = ($urandom_range(2) == 0);
            ifc.mem_rdata   = 16'($urandom);
            ifc.instr_ready = $urandom_range(1);
            ifc.pc_load     = ($urandom_range(9) < 3);
            case ($urandom_range(7))
                0:       ifc.pc_next = 16'hFFFF;
                1:       ifc.pc_next = 16'h0000;
                default: ifc.pc_next = 16'($urandom);
            endcase
            ifc.rlink_valid = $urandom_range(1);
            ifc.rlink_in    = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
